// File: rtl/pio_sample_read_master_pkg.sv
// Shared definitions for the PIO sample read master: FSM encoding, PIO register map
// and skip counter width.
package pio_sample_read_master_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_LAT   = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;

    localparam logic [1:0] PIO_REG_DATA      = 2'd0;
    localparam logic [1:0] PIO_REG_DIRECTION = 2'd1;
    localparam logic [1:0] PIO_REG_IRQ_MASK  = 2'd2;
    localparam logic [1:0] PIO_REG_EDGE_CAP  = 2'd3;

    localparam int SKIP_W = 16;

endpackage

// File: rtl/pio_sample_read_master_if.sv
// Avalon-MM read-only bus between the sample read master and a PIO slave s1 port.
interface pio_sample_read_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/pio_sample_fifo.sv
// Synchronous first-word-fall-through sample buffer with occupancy output.
module pio_sample_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_data,
    output logic                        valid,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A pop on empty is dropped; a push into a full buffer only lands if a pop frees the slot.
    assign do_pop  = pop && (level != '0);
    assign do_push = push && ((level != LVL_W'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = (level != '0);

endmodule

// File: rtl/pio_sample_read_master.sv
// Periodically reads one PIO slave register over Avalon-MM and queues each word
// into a FWFT buffer exposed as a valid/ready sample stream.
module pio_sample_read_master
    import pio_sample_read_master_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 2,
    parameter int RD_ADDR      = PIO_REG_DATA,
    parameter int READ_LATENCY = 1,
    parameter int PERIOD       = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    pio_sample_read_master_if.master        avm,
    output logic [DATA_W-1:0]               sample_data,
    output logic                            sample_valid,
    input  logic                            sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [SKIP_W-1:0]               skip_count
);
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = LVL_W + 1;

    logic [2:0]        state;
    logic [CNT_W-1:0]  period_cnt;
    logic [2:0]        lat_cnt;
    logic              tick;
    logic              reserved;
    logic              has_room;
    logic              issue_ok;
    logic [OCC_W-1:0]  occupied;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A read in flight already owns a buffer slot, so it counts against free space.
    assign tick     = enable && (state != ST_IDLE) && (period_cnt == CNT_W'(PERIOD - 1));
    assign reserved = (state == ST_ISSUE) || (state == ST_LAT) || (state == ST_PUSH);
    assign occupied = {1'b0, fifo_level} + OCC_W'(reserved);
    assign has_room = occupied < OCC_W'(FIFO_DEPTH);
    assign issue_ok = tick && (state == ST_WAIT) && has_room;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            lat_cnt    <= '0;
            skip_count <= '0;
        end else begin
            if (state == ST_IDLE) begin
                period_cnt <= '0;
            end else if (enable) begin
                period_cnt <= (period_cnt == CNT_W'(PERIOD - 1)) ? '0 : period_cnt + 1'b1;
            end

            // Any tick that does not start a read is lost: either no room or a read is busy.
            if (tick && !issue_ok) skip_count <= sat_inc(skip_count);

            case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!enable)       state <= ST_IDLE;
                    else if (issue_ok) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!avm.avm_waitrequest) begin
                        state   <= ST_LAT;
                        lat_cnt <= 3'(READ_LATENCY - 1);
                    end
                end
                ST_LAT: begin
                    if (lat_cnt == '0) state <= ST_PUSH;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                ST_PUSH: begin
                    state <= enable ? ST_WAIT : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign avm.avm_read    = (state == ST_ISSUE);
    assign avm.avm_address = (state == ST_ISSUE) ? ADDR_W'(RD_ADDR) : '0;

    // Stage p1: readdata captured on the last latency cycle, pushed while in PUSH.
    always_ff @(posedge clk) begin
        if ((state == ST_LAT) && (lat_cnt == '0)) rdata_p1 <= avm.avm_readdata;
    end

    assign vld_p1 = (state == ST_PUSH);

    pio_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_p1),
        .push_data (rdata_p1),
        .pop       (sample_ready),
        .pop_data  (sample_data),
        .valid     (sample_valid),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_pio_sample_read_master.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-timestamped reference model of the sampler and its buffer.
module tb_pio_sample_read_master;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 2;
    localparam int RD_ADDR      = 0;
    localparam int READ_LATENCY = 1;
    localparam int PERIOD       = 16;
    localparam int FIFO_DEPTH   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              sample_ready;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic [3:0]        fifo_level;
    logic [15:0]       skip_count;

    pio_sample_read_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avm_if ();

    pio_sample_read_master #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .RD_ADDR      (RD_ADDR),
        .READ_LATENCY (READ_LATENCY),
        .PERIOD       (PERIOD),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .avm          (avm_if),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .skip_count   (skip_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for a tick, 2 read outstanding.
    bit          m_known = 1'b0;
    int          m_phase = 0;
    int          m_cnt   = 0;
    int          m_skip  = 0;
    bit          m_acc   = 1'b0;
    longint      m_cap   = 0;
    longint      m_push  = 0;
    logic [31:0] m_word  = '0;
    logic [31:0] m_q[$];
    longint      cyc     = 0;

    // Stimulus modes and observation counters.
    bit     fixed_word = 1'b0;
    bit     wr_random  = 1'b0;
    int     stall_left = 0;
    int     rd_cycles  = 0;
    int     accepts    = 0;
    longint acc_cyc    = -1;
    longint first_valid = -1;
    longint base_cyc   = 0;
    bit     seen;
    bit     en;
    int     rdy_pct;

    task automatic clear_obs();
        rd_cycles   = 0;
        accepts     = 0;
        acc_cyc     = -1;
        first_valid = -1;
        base_cyc    = cyc;
    endtask

    task automatic model_edge(input bit en_i, input bit rdy_i, input bit rst_i,
                              input bit wr_i, input logic [31:0] rd_i);
        int  pre;
        bit  tick, push_now, accept_now, room;
        if (rst_i) begin
            m_known = 1'b1;
            m_phase = 0;
            m_cnt   = 0;
            m_skip  = 0;
            m_acc   = 1'b0;
            m_q.delete();
        end else if (m_known) begin
            pre        = m_q.size();
            room       = pre < FIFO_DEPTH;
            tick       = en_i && (m_phase != 0) && (m_cnt == PERIOD - 1);
            push_now   = (m_phase == 2) && m_acc && (cyc == m_push);
            accept_now = (m_phase == 2) && !m_acc && !wr_i;
            if ((m_phase == 2) && m_acc && (cyc == m_cap)) m_word = rd_i;
            if (m_phase == 0)  m_cnt = 0;
            else if (en_i)     m_cnt = (m_cnt + 1) % PERIOD;
            if (tick && !((m_phase == 1) && room)) m_skip = (m_skip < 65535) ? m_skip + 1 : m_skip;
            if (rdy_i && pre > 0) void'(m_q.pop_front());
            if (push_now) m_q.push_back(m_word);
            case (m_phase)
                0: if (en_i) m_phase = 1;
                1: begin
                    if (!en_i) m_phase = 0;
                    else if (tick && room) begin
                        m_phase = 2;
                        m_acc   = 1'b0;
                    end
                end
                default: begin
                    if (accept_now) begin
                        m_acc  = 1'b1;
                        m_cap  = cyc + READ_LATENCY;
                        m_push = cyc + READ_LATENCY + 1;
                    end else if (push_now) begin
                        m_phase = en_i ? 1 : 0;
                        m_acc   = 1'b0;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic step(input bit en_i, input bit rdy_i, input bit rst_i);
        bit          exp_read;
        bit          wr;
        logic [31:0] rd;
        exp_read = (m_phase == 2) && !m_acc;
        if (m_known) begin
            check("avm_read", avm_if.avm_read, exp_read);
            check("avm_address", avm_if.avm_address, exp_read ? RD_ADDR : 0);
            check("sample_valid", sample_valid, m_q.size() != 0);
            check("fifo_level", fifo_level, m_q.size());
            check("skip_count", skip_count, m_skip);
            if (m_q.size() != 0) check("sample_data", sample_data, m_q[0]);
        end
        if (wr_random) begin
            wr = ($urandom_range(0, 99) < 30);
        end else if (stall_left > 0 && exp_read) begin
            wr = 1'b1;
            stall_left--;
        end else begin
            wr = 1'b0;
        end
        rd = fixed_word ? 32'hA5A5_0001 : $urandom();
        reset                  = rst_i;
        enable                 = en_i;
        sample_ready           = rdy_i;
        avm_if.avm_waitrequest = wr;
        avm_if.avm_readdata    = rd;
        if (avm_if.avm_read === 1'b1) begin
            rd_cycles++;
            if (!wr) begin
                accepts++;
                acc_cyc = cyc;
            end
        end
        if (sample_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        model_edge(en_i, rdy_i, rst_i, wr, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b1;
        enable                 = 1'b0;
        sample_ready           = 1'b0;
        avm_if.avm_waitrequest = 1'b0;
        avm_if.avm_readdata    = '0;
        @(posedge clk);
        #1;

        // Single sample with a fixed word, no stalls.
        fixed_word = 1'b1;
        step(0, 0, 1);
        step(0, 0, 1);
        check("reset_level", fifo_level, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_skip", skip_count, 0);
        check("reset_read", avm_if.avm_read, 0);
        clear_obs();
        repeat (30) step(1, 0, 0);
        check("t1_read_cycles", rd_cycles, 1);
        check("t1_accept_cycle", acc_cyc - base_cyc, PERIOD + 1);
        check("t1_valid_latency", first_valid - acc_cyc, READ_LATENCY + 2);
        check("t1_data", sample_data, 32'hA5A5_0001);
        fixed_word = 1'b0;

        // Ten periods with no consumer: buffer fills, the rest are skipped.
        step(0, 0, 1);
        clear_obs();
        repeat (170) step(1, 0, 0);
        check("t2_accepts", accepts, FIFO_DEPTH);
        check("t2_level", fifo_level, FIFO_DEPTH);
        check("t2_skips", skip_count, 2);
        check("t2_valid", sample_valid, 1);

        // Free one slot, then pop in the very cycle the next word is pushed.
        step(1, 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if ((m_phase == 2) && m_acc && (cyc == m_push)) begin
                step(1, 1, 0);
                seen = 1'b1;
                check("t5_level_kept", fifo_level, FIFO_DEPTH - 1);
            end else begin
                step(1, 0, 0);
            end
        end
        check("t5_pushpop_seen", seen, 1);

        // Slave stalls the first read for three cycles.
        step(0, 0, 1);
        clear_obs();
        stall_left = 3;
        repeat (30) step(1, 0, 0);
        check("t3_read_cycles", rd_cycles, 4);
        check("t3_accepts", accepts, 1);
        check("t3_level", fifo_level, 1);

        // enable drops in the cycle after accept.
        step(0, 0, 1);
        clear_obs();
        for (int i = 0; i < 40 && accepts == 0; i++) step(1, 0, 0);
        check("t4_accept_seen", accepts, 1);
        repeat (40) step(0, 0, 0);
        check("t4_level", fifo_level, 1);
        check("t4_read_cycles", rd_cycles, 1);

        // Reset lands while the read is in its latency cycle.
        step(0, 0, 1);
        clear_obs();
        for (int i = 0; i < 40 && accepts == 0; i++) step(1, 0, 0);
        check("t6_accept_seen", accepts, 1);
        step(1, 0, 1);
        check("t6_read", avm_if.avm_read, 0);
        check("t6_level", fifo_level, 0);
        repeat (20) step(0, 0, 0);
        check("t6_level_after", fifo_level, 0);
        check("t6_valid_after", sample_valid, 0);

        // Randomized traffic: stalls, consumer back-pressure, enable toggles, resets.
        wr_random = 1'b1;
        en = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 99) < 3) en = !en;
                step(en, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 999) < 3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
